// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
`ifndef INSTR_FETCH_ENDIAN_SWP
`define INSTR_FETCH_ENDIAN_SWP
`define ENDIAN_SWP_32(x) {x[7:0], x[15:8], x[23:16], x[31:24]}
`endif

package instr_fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Registered {pc, instr} queue with synchronous flush; push and pop may
// coincide when full.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response capture
// with PC tagging, and redirect flush/drain of in-flight responses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned DEPTH          = 2,
  parameter bit          MEM_BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             req_fire, rsp_keep, rsp_drop, deq, push;
  logic [31:0]      rsp_word, redirect_aligned;
  logic [CNT_W-1:0] occ_d;
  logic [SUM_W-1:0] credit_used;
  fetch_entry_t     push_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (deq),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    req_fire         = req_valid_q && imem_req_ready;
    rsp_drop         = imem_rsp_valid && (discard_q != '0);
    rsp_keep         = imem_rsp_valid && (discard_q == '0);
    deq              = !fifo_empty && dec_ready;
    push             = rsp_keep && (!fifo_full || deq);
    rsp_word         = MEM_BIG_ENDIAN ? `ENDIAN_SWP_32(imem_rsp_data) : imem_rsp_data;
    push_entry       = '{pc: rsp_pc_q, instr: rsp_word};
    redirect_aligned = {redirect_pc[31:2], 2'b00};

    state_d   = state_q;
    out_d     = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    pc_d      = req_fire ? pc_q + 32'd4 : pc_q;
    rsp_pc_d  = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    discard_d = discard_q - CNT_W'(rsp_drop);

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   if (discard_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d      = redirect_aligned;
      rsp_pc_d  = redirect_aligned;
      discard_d = out_d;
      state_d   = (out_d != '0) ? DRAIN : FETCH;
    end

    occ_d       = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(deq);
    credit_used = SUM_W'(out_d) + SUM_W'(occ_d);
    req_valid_d = (state_d == FETCH) && (credit_used < SUM_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      out_q       <= '0;
      discard_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      req_valid_q <= req_valid_d;
      out_q       <= out_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign dec_valid      = !fifo_empty;
  assign dec_instr      = fifo_empty ? 32'd0 : head.instr;
  assign dec_pc         = fifo_empty ? 32'd0 : head.pc;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction queue entries (power of two, 2..8).
REQ-003 Parameter MEM_BIG_ENDIAN, default 1, byte-swap imem_rsp_data (32-bit endian swap) before enqueue when 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_pc  input  32  new fetch address.
REQ-013 dec_valid  output  1  instruction available to decode/immediate generation.
REQ-014 dec_ready  input  1  decode consumes instruction this cycle.
REQ-015 dec_instr  output  32  instruction, little-endian RV32 encoding.
REQ-016 dec_pc  output  32  address of dec_instr.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN; IDLE -> FETCH unconditionally one cycle after reset release.
REQ-018 Request handshake completes when imem_req_valid && imem_req_ready; fetch PC then advances by 4 (mod 2^32 wrap, 32'hFFFF_FFFC -> 0).
REQ-019 imem_req_valid shall be 1 only in FETCH and only when outstanding + queue occupancy < DEPTH (credit rule; no response ever lost).
REQ-020 imem_req_valid/imem_req_addr shall hold stable while valid && !ready, unless redirect_valid.
REQ-021 Each accepted response enqueued with its request PC; enqueue and dequeue in same cycle permitted at full or empty.
REQ-022 dec_valid = queue non-empty; dec_instr/dec_pc = queue head; dequeue on dec_valid && dec_ready.
REQ-023 Pass-through latency: response in cycle N -> dec_valid in cycle N+1 (registered queue, no combinational rsp->dec path).
REQ-024 redirect_valid: flush queue next cycle, fetch PC <= {redirect_pc[31:2],2'b00}, discard count <= outstanding requests (including one accepted this cycle).
REQ-025 Redirect with discard count > 0 -> DRAIN; responses dropped, count decremented; count 0 -> FETCH, no requests issued in DRAIN.
REQ-026 Redirect with no outstanding -> remain/enter FETCH, request at redirect_pc next cycle.
REQ-027 Redirect coincident with dec handshake: head counts as consumed; flush still applies to all entries.
REQ-028 Redirect during DRAIN: new target replaces pending PC, discard count accumulates correctly.
REQ-029 Response while queue full is impossible under REQ-019; assertion in bench, no RTL handling.

Reset
REQ-030 During rst: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, queue empty, outstanding=0, discard=0, state IDLE.
REQ-031 Reset mid-operation abandons outstanding requests; memory reset together; responses with rst high ignored.

Structure
REQ-032 Shared package: FSM state enum, RV32 NOP constant 32'h0000_0013, ENDIAN_SWP_32 macro in common header.
REQ-033 Sub-module instr_fifo (DEPTH x 64-bit {pc,instr}, sync flush, full/empty/count); fetch FSM and credit logic in instr_fetch.

Verification
REQ-034 Reset RESET_PC=0x100, memory 1-cycle latency, dec_ready=1 -> addresses 0x100,0x104,0x108 in order; dec_pc matches; first dec_valid 3 cycles after rst release.
REQ-035 MEM_BIG_ENDIAN=1, rsp_data 0x93001000 -> dec_instr 0x00100093.
REQ-036 dec_ready=0 for 10 cycles -> exactly DEPTH requests issued, then req_valid=0; dec_ready=1 -> resumes, no duplicates or gaps.
REQ-037 Redirect to 0x2002 with 2 outstanding -> DRAIN drops 2 responses, next request 0x2000, no stale dec_valid.
REQ-038 imem_req_ready=0 for 5 cycles -> addr stable; fetch PC 0xFFFFFFFC -> next 0x00000000.
REQ-039 rst asserted with queue full -> dec_valid=0 next cycle, first request at RESET_PC.
